// File: rtl/rcvr_frame_pkg.sv
// Shared types and width helpers for the framed serial receiver.
package rcvr_frame_pkg;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_BODY = 1'b1
  } state_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int clog2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rcvr_fifo.sv
// Show-ahead synchronous FIFO with occupancy level and drop strobe.
module rcvr_fifo
  import rcvr_frame_pkg::*;
#(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           i_push,
  input  logic [W-1:0]                   i_din,
  input  logic                           i_pop,
  output logic                           o_ready,
  output logic [W-1:0]                   o_dout,
  output logic [$clog2(DEPTH+1)-1:0]     o_level,
  output logic                           o_drop
);

  localparam int PW = clog2w(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [LW-1:0] r_level;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_wr;

  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_pop   = i_pop & ~w_empty;
  // A full FIFO still accepts a word when its head leaves the same cycle.
  assign w_wr    = i_push & (~w_full | w_pop);
  assign o_drop  = i_push & w_full & ~w_pop;

  assign o_ready = ~w_empty;
  assign o_level = r_level;
  assign o_dout  = w_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      unique case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/rcvr_frame.sv
// Serial header hunter and word deserialiser feeding a show-ahead FIFO.
module rcvr_frame
  import rcvr_frame_pkg::*;
#(
  parameter int               HDR_W           = 8,
  parameter logic [HDR_W-1:0] MATCH           = HDR_W'(8'hA5),
  parameter int               DATA_W          = 8,
  parameter int               WORDS_PER_FRAME = 1,
  parameter int               FIFO_DEPTH      = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              data_in,
  input  logic                              reading,
  output logic                              ready,
  output logic [DATA_W-1:0]                 data_out,
  output logic                              data_last,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
  output logic                              overrun,
  output logic                              in_frame
);

  localparam int BW = clog2w(DATA_W);
  localparam int WW = clog2w(WORDS_PER_FRAME);
  localparam logic [HDR_W-2:0] HEAD_INIT =
    {(HDR_W-1){~MATCH[HDR_W-1]}};
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(WORDS_PER_FRAME - 1);

  state_t            r_state;
  logic [HDR_W-2:0]  r_head;
  logic [DATA_W-2:0] r_body;
  logic [BW-1:0]     r_bit_cnt;
  logic [WW-1:0]     r_word_cnt;
  logic              r_push;
  logic [DATA_W:0]   r_word;
  logic              r_ovr;

  logic [HDR_W-1:0]  w_hdr;
  logic [DATA_W-1:0] w_body;
  logic              w_last;
  logic [DATA_W:0]   w_dout;
  logic              w_drop;

  assign w_hdr  = {r_head, data_in};
  assign w_body = {r_body, data_in};
  assign w_last = (r_word_cnt == WORD_LAST);

  // Completed word is held one cycle so it appears the edge after its last bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_HUNT;
      r_head     <= HEAD_INIT;
      r_body     <= '0;
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_push     <= 1'b0;
      r_word     <= '0;
    end else begin
      r_push <= 1'b0;
      unique case (r_state)
        ST_HUNT: begin
          r_head <= w_hdr[HDR_W-2:0];
          if (w_hdr == MATCH) begin
            r_state    <= ST_BODY;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
          end
        end
        ST_BODY: begin
          r_body <= w_body[DATA_W-2:0];
          if (r_bit_cnt == BIT_LAST) begin
            r_push    <= 1'b1;
            r_word    <= {w_last, w_body};
            r_bit_cnt <= '0;
            if (w_last) begin
              r_state    <= ST_HUNT;
              r_head     <= HEAD_INIT;
              r_word_cnt <= '0;
            end else begin
              r_word_cnt <= r_word_cnt + 1'b1;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        default: r_state <= ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       r_ovr <= 1'b0;
    else if (w_drop)  r_ovr <= 1'b1;
    else if (reading) r_ovr <= 1'b0;
  end

  rcvr_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (r_push),
    .i_din   (r_word),
    .i_pop   (reading),
    .o_ready (ready),
    .o_dout  (w_dout),
    .o_level (level),
    .o_drop  (w_drop)
  );

  assign data_out  = w_dout[DATA_W-1:0];
  assign data_last = w_dout[DATA_W];
  assign overrun   = r_ovr;
  assign in_frame  = (r_state == ST_BODY);

endmodule

// File: tb/tb_rcvr_frame.sv
// Bench for rcvr_frame: vector table, corner sequences, randomized model.
module tb_rcvr_frame;

  localparam logic [7:0] MATCH = 8'hA5;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       data_in = 1'b0;
  logic       reading = 1'b0;
  logic       ready;
  logic [7:0] data_out;
  logic       data_last;
  logic [2:0] level;
  logic       overrun;
  logic       in_frame;

  logic       d2 = 1'b0;
  logic       rd2 = 1'b0;
  logic       ready2;
  logic [7:0] dout2;
  logic       last2;
  logic [2:0] level2;
  logic       ovr2;
  logic       inf2;

  int total = 0;
  int passed = 0;

  always #5 clock = ~clock;

  rcvr_frame dut (
    .clock(clock), .reset(reset), .data_in(data_in), .reading(reading),
    .ready(ready), .data_out(data_out), .data_last(data_last),
    .level(level), .overrun(overrun), .in_frame(in_frame)
  );

  rcvr_frame #(.WORDS_PER_FRAME(2)) dut2 (
    .clock(clock), .reset(reset), .data_in(d2), .reading(rd2),
    .ready(ready2), .data_out(dout2), .data_last(last2),
    .level(level2), .overrun(ovr2), .in_frame(inf2)
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      data_in = v[i];
      tick();
    end
    data_in = 1'b0;
  endtask

  task automatic send2(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) begin
      d2 = v[i];
      tick();
    end
    d2 = 1'b0;
  endtask

  // Behavioural reference: bit window, word accumulator, FIFO as a queue.
  bit         m_body_mode;
  int         m_win;
  int         m_acc;
  int         m_bits;
  bit         m_pend;
  logic [8:0] m_pword;
  logic [8:0] m_q[$];
  bit         m_ovr;

  function automatic int hunt_init();
    return MATCH[7] ? 0 : 'h7F;
  endfunction

  task automatic model_reset;
    m_body_mode = 0;
    m_win = hunt_init();
    m_acc = 0;
    m_bits = 0;
    m_pend = 0;
    m_q.delete();
    m_ovr = 0;
  endtask

  task automatic model_step(input bit b, input bit rd);
    bit full, pop, drop;
    int cand;
    full = (m_q.size() == DEPTH);
    pop  = rd && (m_q.size() > 0);
    drop = 0;
    if (pop) void'(m_q.pop_front());
    if (m_pend) begin
      if (!full || pop) m_q.push_back(m_pword);
      else drop = 1;
    end
    if (drop) m_ovr = 1;
    else if (rd) m_ovr = 0;
    m_pend = 0;
    if (!m_body_mode) begin
      cand = ((m_win << 1) | int'(b)) & 'hFF;
      if (cand == int'(MATCH)) begin
        m_body_mode = 1;
        m_bits = 0;
      end else m_win = cand;
    end else begin
      m_acc = ((m_acc << 1) | int'(b)) & 'hFF;
      m_bits++;
      if (m_bits == 8) begin
        m_pend = 1;
        m_pword = {1'b1, m_acc[7:0]};
        m_body_mode = 0;
        m_win = hunt_init();
      end
    end
  endtask

  function automatic logic [14:0] model_vec();
    logic [8:0] h;
    h = (m_q.size() > 0) ? m_q[0] : 9'h0;
    return {m_q.size() > 0, h[8], m_ovr, m_body_mode,
            3'(m_q.size()), h[7:0]};
  endfunction

  typedef struct {
    logic [15:0] noise;
    int          nnoise;
    logic [7:0]  payload;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vt[4];
  bit   sq[$];

  initial begin
    vt[0] = '{16'h4A, 8, 8'h3C, 8'h3C};
    vt[1] = '{16'h0, 0, 8'hA5, 8'hA5};
    vt[2] = '{16'h6, 4, 8'h00, 8'h00};
    vt[3] = '{16'h0, 0, 8'hFF, 8'hFF};

    repeat (3) tick();
    chk("reset_ready", ready, 0);
    chk("reset_level", level, 0);
    chk("reset_dout", data_out, 0);
    chk("reset_flags", {data_last, overrun, in_frame}, 0);
    reset = 1'b1;
    tick();

    // Basic frame and one-cycle latency.
    send(16'hA5, 8);
    chk("hdr_enters_body", in_frame, 1);
    send(16'h3C, 8);
    chk("latency_not_yet", ready, 0);
    chk("back_to_hunt", in_frame, 0);
    tick();
    chk("basic_dout", data_out, 8'h3C);
    chk("basic_ready_last", {ready, data_last}, 2'b11);
    chk("basic_level", level, 1);
    reading = 1'b1;
    tick();
    reading = 1'b0;
    chk("basic_popped", level, 0);

    for (int i = 0; i < 4; i++) begin
      send(vt[i].noise, vt[i].nnoise);
      send(16'(MATCH), 8);
      send(16'(vt[i].payload), 8);
      tick();
      chk($sformatf("vec%0d_dout", i), data_out, vt[i].exp_data);
      chk($sformatf("vec%0d_lvl", i), {level, data_last, overrun}, 5'b00110);
      reading = 1'b1;
      tick();
      reading = 1'b0;
      chk($sformatf("vec%0d_pop", i), level, 0);
    end

    // Overflow: five frames with no reads.
    for (int i = 1; i <= 5; i++) begin
      send(16'(MATCH), 8);
      send(16'(i * 'h11), 8);
    end
    tick();
    chk("full_level", level, 4);
    chk("full_overrun", overrun, 1);
    chk("full_head_oldest", data_out, 8'h11);
    reading = 1'b1;
    tick();
    reading = 1'b0;
    chk("ovr_cleared", overrun, 0);
    chk("pop_level", level, 3);
    chk("pop_head", data_out, 8'h22);

    send(16'(MATCH), 8);
    send(16'h66, 8);
    send(16'(MATCH), 8);
    chk("refill_level", level, 4);
    send(16'h77, 8);
    reading = 1'b1;
    tick();
    reading = 1'b0;
    chk("pushpop_full_level", level, 4);
    chk("pushpop_no_ovr", overrun, 0);
    begin
      logic [7:0] exp_drain[4];
      exp_drain = '{8'h33, 8'h44, 8'h66, 8'h77};
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("drain%0d", i), data_out, exp_drain[i]);
        reading = 1'b1;
        tick();
        reading = 1'b0;
      end
    end
    chk("drained_level", level, 0);
    reading = 1'b1;
    tick();
    reading = 1'b0;
    chk("read_empty", {ready, level, data_out}, 0);

    // Asynchronous reset in the middle of a payload word.
    send(16'(MATCH), 8);
    send(16'h5A, 8);
    send(16'(MATCH), 8);
    send(16'h9, 4);
    chk("pre_reset_state", {in_frame, level}, 4'b1001);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_out", {ready, data_out, data_last, level, overrun, in_frame},
        0);
    tick();
    reset = 1'b1;
    send(16'(MATCH), 8);
    send(16'hC3, 8);
    tick();
    chk("post_rst_frame", {ready, data_out, level}, {1'b1, 8'hC3, 3'd1});

    // Two-word frames on the second instance.
    for (int i = 7; i >= 0; i--) begin
      d2 = MATCH[i];
      tick();
    end
    send2(8'h12);
    chk("w2_still_body", inf2, 1);
    send2(8'h34);
    tick();
    chk("w2_hunt", inf2, 0);
    chk("w2_first", {level2, last2, dout2}, {3'd2, 1'b0, 8'h12});
    rd2 = 1'b1;
    tick();
    rd2 = 1'b0;
    chk("w2_second", {level2, last2, dout2}, {3'd1, 1'b1, 8'h34});

    // Randomized run against the reference model.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      bit b, rd;
      logic [7:0] pl;
      if (sq.size() == 0) begin
        if ($urandom_range(0, 2) != 0) begin
          pl = 8'($urandom);
          for (int i = 7; i >= 0; i--) sq.push_back(MATCH[i]);
          for (int i = 7; i >= 0; i--) sq.push_back(pl[i]);
        end else begin
          for (int i = 0; i < $urandom_range(1, 5); i++)
            sq.push_back(1'($urandom));
        end
      end
      b  = sq.pop_front();
      rd = ($urandom_range(0, 3) == 0);
      data_in = b;
      reading = rd;
      tick();
      model_step(b, rd);
      chk("rand", {ready, data_last, overrun, in_frame, level, data_out},
          32'(model_vec()));
    end
    reading = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
